// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the mini CPU: instruction field positions, opcodes,
// ALU opcode values (shared with the ALU) and the sequencer state encoding.
package cpu_defs;

   localparam int OPC_HI = 11;
   localparam int OPC_LO = 8;
   localparam int RD_HI  = 7;
   localparam int RD_LO  = 6;
   localparam int RS_HI  = 5;
   localparam int RS_LO  = 4;
   localparam int IMM_HI = 3;
   localparam int IMM_LO = 0;

   // Opcodes 0x0-0x7 go to the ALU with opcode[2:0] as the ALU operation.
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_OUT  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_NOT = 3'd5;
   localparam logic [2:0] ALU_SHL = 3'd6;
   localparam logic [2:0] ALU_SHR = 3'd7;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_OUT_WAIT,
      S_HALT
   } state_e;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return ~opc[3];
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, cleared by the asynchronous reset.
module cpu_regfile #(
   parameter int DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [1:0]        i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [1:0]        i_raddr_a,
   input  logic [1:0]        i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);
   logic [DATA_W-1:0] r_mem [4];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the mini CPU; issues operands to an
// external combinational ALU and owns a ready/valid output port.
//
// state      | meaning
// S_FETCH    | present pc to the instruction ROM
// S_DECODE   | ROM data valid, latch it into ir
// S_EXECUTE  | perform the instruction, advance pc
// S_OUT_WAIT | out_valid high until the consumer accepts out_data
// S_HALT     | stopped until reset
module cpu_control_unit
   import cpu_defs::*;
#(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [8+DATA_W-1:0] imem_rdata,
   output logic [2:0]          alu_op,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_result,
   input  logic                alu_zero,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                halted
);
   state_e              r_state, w_state_nxt;
   logic [PC_W-1:0]     r_pc, w_pc_nxt;
   logic [8+DATA_W-1:0] r_ir;
   logic                r_zflag, w_zflag_nxt;
   logic [DATA_W-1:0]   r_out_data, w_out_data_nxt;
   logic                w_we;
   logic [DATA_W-1:0]   w_wdata;
   logic [3:0]          w_opc, w_imm;
   logic [1:0]          w_rd, w_rs;

   assign w_opc = r_ir[OPC_HI:OPC_LO];
   assign w_rd  = r_ir[RD_HI:RD_LO];
   assign w_rs  = r_ir[RS_HI:RS_LO];
   assign w_imm = r_ir[IMM_HI:IMM_LO];

   // Port A always reads rd, so it doubles as the OUT source.
   cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_we      (w_we),
      .i_waddr   (w_rd),
      .i_wdata   (w_wdata),
      .i_raddr_a (w_rd),
      .i_raddr_b (w_rs),
      .o_rdata_a (alu_a),
      .o_rdata_b (alu_b)
   );

   assign alu_op    = w_opc[2:0];
   assign imem_addr = r_pc;
   assign out_data  = r_out_data;
   assign out_valid = (r_state == S_OUT_WAIT);
   assign halted    = (r_state == S_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pc       <= '0;
         r_ir       <= '0;
         r_zflag    <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_zflag    <= w_zflag_nxt;
         r_out_data <= w_out_data_nxt;
         if (r_state == S_DECODE) r_ir <= imem_rdata;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_zflag_nxt    = r_zflag;
      w_out_data_nxt = r_out_data;
      w_we           = 1'b0;
      w_wdata        = alu_result;
      unique case (r_state)
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXECUTE;
         S_EXECUTE: begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = r_pc + PC_W'(1);
            if (is_alu_op(w_opc)) begin
               w_we        = 1'b1;
               w_zflag_nxt = alu_zero;
            end else begin
               case (w_opc)
                  OP_LDI: begin
                     w_we    = 1'b1;
                     w_wdata = DATA_W'(w_imm);
                  end
                  OP_JZ:  if (r_zflag) w_pc_nxt = PC_W'(w_imm);
                  OP_JMP: w_pc_nxt = PC_W'(w_imm);
                  OP_OUT: begin
                     // pc advances on the handshake edge instead
                     w_pc_nxt       = r_pc;
                     w_out_data_nxt = alu_a;
                     w_state_nxt    = S_OUT_WAIT;
                  end
                  OP_HALT: w_state_nxt = S_HALT;
                  default: ;
               endcase
            end
         end
         S_OUT_WAIT: begin
            if (out_ready) begin
               w_pc_nxt    = r_pc + PC_W'(1);
               w_state_nxt = S_FETCH;
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_FETCH;
      endcase
   end

endmodule
